// File: rtl/vga_write_sched_pkg.sv
// Shared definitions for the VGA write scheduler: register map,
// PIXEL/STATUS field layout and FSM encoding.
package vga_write_sched_pkg;

   localparam logic [3:0] OFF_PIXEL  = 4'h0;
   localparam logic [3:0] OFF_FILL   = 4'h4;
   localparam logic [3:0] OFF_STATUS = 4'h8;
   localparam logic [3:0] OFF_CTRL   = 4'hC;

   localparam int COLOR_W = 12;
   localparam int COORD_W = 9;
   localparam int PIX_W   = COLOR_W + 2 * COORD_W;

   localparam int ST_FILL_BIT  = 8;
   localparam int ST_OVF_BIT   = 9;
   localparam int ST_RANGE_BIT = 10;
   localparam int ST_VSYNC_BIT = 11;

   localparam int CTRL_CLR_BIT   = 0;
   localparam int CTRL_VSYNC_BIT = 1;

   // Field order matches the PIXEL register: y[29:21] x[20:12] c[11:0]
   typedef struct packed {
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] x;
      logic [COLOR_W-1:0] c;
   } pixel_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_FRAME,
      S_DRAIN,
      S_FILL
   } state_t;

   function automatic pixel_t unpack_pixel(input logic [31:0] w);
      return pixel_t'(w[PIX_W-1:0]);
   endfunction

endpackage

// File: rtl/vga_write_sched_if.sv
// Core I/O bus, frame trigger and frame-memory write port of the
// VGA write scheduler, bundled for the CPU side (master) and block (slave).
interface vga_write_sched_if
   import vga_write_sched_pkg::*;
#(
   parameter int ADDR_W = 17
);

   logic [31:0]        bus_addr;
   logic [31:0]        bus_wdata;
   logic               bus_we;
   logic [31:0]        bus_rdata;
   logic               frame_trig;
   logic               mem_we;
   logic [ADDR_W-1:0]  mem_addr;
   logic [COLOR_W-1:0] mem_data;

   modport master (
      output bus_addr, bus_wdata, bus_we, frame_trig,
      input  bus_rdata, mem_we, mem_addr, mem_data
   );

   modport slave (
      input  bus_addr, bus_wdata, bus_we, frame_trig,
      output bus_rdata, mem_we, mem_addr, mem_data
   );

endinterface

// File: rtl/vga_write_sched_sync_fifo.sv
// Single-clock FIFO with flush; a pop frees space for a same-cycle push.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 30,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [LW-1:0]    o_level
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [LW-1:0]    r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_level == LW'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_rdata   = r_mem[r_rptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + AW'(1);
         if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
         if (w_do_push && !w_do_pop)
            r_level <= r_level + LW'(1);
         else if (w_do_pop && !w_do_push)
            r_level <= r_level - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wptr] <= i_wdata;
   end

endmodule

// File: rtl/vga_write_sched.sv
// CPU-side write scheduler for the VGA frame memory: register decode,
// pixel FIFO, screen-fill engine and single write-port arbitration.
module vga_write_sched
   import vga_write_sched_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h0001_0000,
   parameter int          DISPLAY_WIDTH  = 400,
   parameter int          DISPLAY_HEIGHT = 300,
   parameter int          FIFO_DEPTH     = 16,
   parameter int          ADDR_W         = 17
) (
   input  logic             clk,
   input  logic             rst,
   vga_write_sched_if.slave bus
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int NPIX  = DISPLAY_WIDTH * DISPLAY_HEIGHT;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

   state_t              r_state;
   state_t              w_next;
   logic                r_ovf;
   logic                r_range;
   logic                r_vsync;
   logic [ADDR_W-1:0]   r_fill_cnt;
   logic [COLOR_W-1:0]  r_fill_color;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [COLOR_W-1:0]  r_mem_data;

   logic                w_wr_pixel;
   logic                w_wr_fill;
   logic                w_wr_ctrl;
   logic                w_rd_status;
   pixel_t              w_in_pix;
   logic                w_in_range;
   logic                w_push;
   logic                w_pop;
   logic                w_fill_issue;
   logic                w_full;
   logic                w_empty;
   logic [LVL_W-1:0]    w_level;
   logic [PIX_W-1:0]    w_head_raw;
   pixel_t              w_head;
   logic [ADDR_W-1:0]   w_pix_addr;
   logic                w_ovf_set;
   logic                w_range_set;
   logic                w_clr;
   logic [31:0]         w_status;
   logic                w_unused;

   always_comb begin
      w_wr_pixel = 1'b0;
      w_wr_fill  = 1'b0;
      w_wr_ctrl  = 1'b0;
      if (bus.bus_we) begin
         unique case (bus.bus_addr)
            BASE_ADDR + 32'(OFF_PIXEL): w_wr_pixel = 1'b1;
            BASE_ADDR + 32'(OFF_FILL):  w_wr_fill  = 1'b1;
            BASE_ADDR + 32'(OFF_CTRL):  w_wr_ctrl  = 1'b1;
            default: ;
         endcase
      end
   end

   assign w_rd_status = (bus.bus_addr == BASE_ADDR + 32'(OFF_STATUS));
   assign w_in_pix    = unpack_pixel(bus.bus_wdata);
   assign w_in_range  = (int'(w_in_pix.x) < DISPLAY_WIDTH) &&
                        (int'(w_in_pix.y) < DISPLAY_HEIGHT);
   assign w_push      = w_wr_pixel && w_in_range;
   assign w_unused    = ^bus.bus_wdata[31:PIX_W];

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PIX_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_wr_fill),
      .i_wdata (w_in_pix),
      .o_rdata (w_head_raw),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   assign w_head     = pixel_t'(w_head_raw);
   assign w_pix_addr = ADDR_W'(w_head.y) * ADDR_W'(DISPLAY_WIDTH) +
                       ADDR_W'(w_head.x);

   assign w_ovf_set   = w_push && w_full && !w_pop;
   assign w_range_set = w_wr_pixel && !w_in_range;
   assign w_clr       = w_wr_ctrl && bus.bus_wdata[CTRL_CLR_BIT];

   // A new error on the clearing edge wins over the clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf   <= 1'b0;
         r_range <= 1'b0;
         r_vsync <= 1'b0;
      end else begin
         r_ovf   <= w_ovf_set | (r_ovf & ~w_clr);
         r_range <= w_range_set | (r_range & ~w_clr);
         if (w_wr_ctrl) r_vsync <= bus.bus_wdata[CTRL_VSYNC_BIT];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:
            if (!w_empty) w_next = r_vsync ? S_WAIT_FRAME : S_DRAIN;
         S_WAIT_FRAME:
            if (bus.frame_trig) w_next = S_DRAIN;
         S_DRAIN:
            if (w_empty) w_next = S_IDLE;
         S_FILL:
            if (r_fill_cnt == LAST_ADDR) w_next = S_IDLE;
         default:
            w_next = S_IDLE;
      endcase
      if (w_wr_fill) w_next = S_FILL;
   end

   // A FILL write flushes the FIFO, so no pop competes with it
   always_comb begin
      w_pop        = 1'b0;
      w_fill_issue = 1'b0;
      unique case (r_state)
         S_DRAIN: w_pop        = !w_empty && !w_wr_fill;
         S_FILL:  w_fill_issue = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fill_cnt   <= '0;
         r_fill_color <= '0;
      end else if (w_wr_fill) begin
         r_fill_cnt   <= '0;
         r_fill_color <= bus.bus_wdata[COLOR_W-1:0];
      end else if (w_fill_issue && r_fill_cnt != LAST_ADDR) begin
         r_fill_cnt   <= r_fill_cnt + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_data <= '0;
      end else begin
         r_mem_we <= w_pop || w_fill_issue;
         if (w_fill_issue) begin
            r_mem_addr <= r_fill_cnt;
            r_mem_data <= r_fill_color;
         end else if (w_pop) begin
            r_mem_addr <= w_pix_addr;
            r_mem_data <= w_head.c;
         end
      end
   end

   always_comb begin
      w_status                = '0;
      w_status[LVL_W-1:0]     = w_level;
      w_status[ST_FILL_BIT]   = (r_state == S_FILL);
      w_status[ST_OVF_BIT]    = r_ovf;
      w_status[ST_RANGE_BIT]  = r_range;
      w_status[ST_VSYNC_BIT]  = r_vsync;
   end

   assign bus.bus_rdata = w_rd_status ? w_status : 32'h0;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_data  = r_mem_data;

endmodule
